airi5c_fetch_ctrl: RTL
======================

Name: airi5c_fetch_ctrl

Overview:
- Instruction-fetch stage directly downstream of the PC multiplexer.
- Takes the next-PC value pc_pif_i, issues single-outstanding requests on a req/gnt/rvalid instruction-memory port, and holds the returned instruction for decode behind a valid/ready handshake.
- Drives pc_if_o and compressed_o back to the mux, which closes the sequential-PC loop.
- Squashes in-flight fetches on redirect (branch, jump, trap, xret, debug).

Parameters:
XPR_LEN, 32, address/data width
INST_WIDTH, 32, instruction width
RESET_PC, 32'h8000_0000, first fetch address after reset

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous, active-high reset
pc_pif_i  in  XPR_LEN  next PC from PC mux (always valid, combinational)
redirect_i  in  1  pc_src_sel is not the sequential default this cycle; pc_pif_i is a redirect target
imem_req_o  out  1  fetch request
imem_addr_o  out  XPR_LEN  fetch address (halfword aligned; memory returns 32 bits starting at addr)
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  response valid (exactly one per granted request, at least 1 cycle after gnt)
imem_rdata_i  in  INST_WIDTH  response data
imem_err_i  in  1  bus error, qualified by rvalid
inst_o  out  INST_WIDTH  held instruction
inst_valid_o  out  1  inst_o/pc_if_o valid for decode
inst_ready_i  in  1  decode accepts the instruction
pc_if_o  out  XPR_LEN  PC of the held/in-flight instruction (to mux pc_if_i)
compressed_o  out  1  inst_o[1:0] != 2'b11 (to mux compressed_i)
fetch_err_o  out  1  held instruction carries a bus error (qualified by inst_valid_o)

Behaviour:
- Reset (rst_i=1 at edge): state=S_REQ, pc_req_q=RESET_PC, pc_if_o=RESET_PC, kill_q=0, inst_valid_o=0, inst_o=0, fetch_err_o=0. rst_i overrides every other input.
- States:
  - S_REQ: imem_req_o=1, imem_addr_o=pc_req_q. The address stays stable until gnt, per protocol. On gnt: pc_if_o<=pc_req_q, go to S_WAIT.
  - S_WAIT: no request. On rvalid with kill_q=0: inst_o<=rdata, fetch_err_o<=err, inst_valid_o<=1, go to S_HOLD.
  - S_HOLD: inst_valid_o=1.
    - If inst_ready_i=1 and redirect_i=0: issue the next request in the same cycle, combinationally: imem_req_o=1, imem_addr_o=pc_pif_i (= pc_if_o+2/+4 from the mux).
    - On gnt: pc_if_o<=pc_pif_i, go to S_WAIT, inst_valid_o<=0.
    - Without gnt: pc_req_q<=pc_pif_i, go to S_REQ, inst_valid_o<=0.
    - Not ready and no redirect: hold all outputs unchanged.
- Redirect (redirect_i=1):
  - S_HOLD: drop the held instruction (inst_valid_o<=0). Issue pc_pif_i combinationally as above, ignoring inst_ready_i.
  - S_REQ without gnt: request is not withdrawn. Set kill_q<=1 and pc_req_q_next<=pc_pif_i (separate redir_pc_q register).
  - S_REQ with gnt, or S_WAIT: kill_q<=1, redir_pc_q<=pc_pif_i.
  - A later redirect while kill_q=1 overwrites redir_pc_q; the last redirect wins.
- Kill: a response arriving with kill_q=1 is discarded (inst_valid_o stays 0). In the same cycle: kill_q<=0, pc_req_q<=redir_pc_q, pc_if_o<=redir_pc_q, go to S_REQ. Redirect and rvalid in the same cycle with kill_q=0: the response is discarded and pc_pif_i becomes the target.
- Latency: request-to-valid is 2 cycles minimum with zero-wait memory (gnt in request cycle, rvalid next cycle). Throughput is 1 instruction / 2 cycles with continuous ready.
- Outstanding requests: never more than 1; imem_req_o=0 in S_WAIT.
- compressed_o is combinational from inst_o. Its value is only meaningful while inst_valid_o=1.
- Bus error: fetch_err_o=1 with inst_o=rdata. Fetch does not stop; trap handling redirects.
- Address arithmetic is done by the mux only; wrap at 2^XPR_LEN is natural.

Decomposition:
- State encodings FETCH_S_REQ/WAIT/HOLD (2 bits) go in airi5c_ctrl_constants.vh.
- RESET_PC default comes from airi5c_arch_options.vh.
- No sub-module; a single FSM file of about 200 lines.

Test Plan:
- Reset then zero-wait memory, ready=1, rdata=32'h00000013: first imem_addr_o=0x8000_0000; inst_valid_o rises 2 cycles later; next address 0x8000_0004.
- Held rdata=16'h4501 (compressed), mux supplies pc+2: next imem_addr_o=0x8000_0002; compressed_o=1.
- inst_ready_i=0 for 5 cycles in S_HOLD: inst_o, pc_if_o and inst_valid_o stable; no imem_req_o.
- redirect_i with pc_pif_i=0x8000_0100 during S_WAIT, rvalid 3 cycles later: response discarded, inst_valid_o never set; next request addr=0x8000_0100.
- Two redirects (0x100, then 0x200) before rvalid: only 0x8000_0200 is fetched; exactly one extra request.
- rvalid with imem_err_i=1 at 0x8000_0008: fetch_err_o=1 with inst_valid_o; rst_i asserted while in S_WAIT returns to S_REQ with addr=RESET_PC next cycle.

Source files
------------

// File: rtl/airi5c_fetch_ctrl_pkg.sv
// Shared types and defaults for the instruction-fetch controller.
// Holds the FSM state encoding, the reset PC and the compressed-instruction test.
package airi5c_fetch_ctrl_pkg;

   localparam int unsigned FETCH_XPR_LEN    = 32;
   localparam int unsigned FETCH_INST_WIDTH = 32;
   localparam logic [31:0] FETCH_RESET_PC   = 32'h8000_0000;

   typedef enum logic [1:0] {
      FETCH_S_REQ  = 2'b00,
      FETCH_S_WAIT = 2'b01,
      FETCH_S_HOLD = 2'b10
   } fetch_state_e;

   // RVC encodings use every low-bit pattern except 2'b11
   function automatic logic is_compressed(input logic [1:0] low_bits);
      return (low_bits != 2'b11);
   endfunction

endpackage

// File: rtl/airi5c_fetch_ctrl.sv
// Instruction-fetch stage: single-outstanding req/gnt/rvalid fetches, a held
// instruction behind valid/ready, and squashing of in-flight fetches on redirect.
module airi5c_fetch_ctrl
   import airi5c_fetch_ctrl_pkg::*;
#(
   parameter int unsigned        XPR_LEN    = FETCH_XPR_LEN,
   parameter int unsigned        INST_WIDTH = FETCH_INST_WIDTH,
   parameter logic [XPR_LEN-1:0] RESET_PC   = FETCH_RESET_PC[XPR_LEN-1:0]
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [XPR_LEN-1:0]    pc_pif_i,
   input  logic                  redirect_i,
   output logic                  imem_req_o,
   output logic [XPR_LEN-1:0]    imem_addr_o,
   input  logic                  imem_gnt_i,
   input  logic                  imem_rvalid_i,
   input  logic [INST_WIDTH-1:0] imem_rdata_i,
   input  logic                  imem_err_i,
   output logic [INST_WIDTH-1:0] inst_o,
   output logic                  inst_valid_o,
   input  logic                  inst_ready_i,
   output logic [XPR_LEN-1:0]    pc_if_o,
   output logic                  compressed_o,
   output logic                  fetch_err_o
);

   fetch_state_e          r_state;
   fetch_state_e          w_state_nxt;
   logic [XPR_LEN-1:0]    r_pc_req;
   logic [XPR_LEN-1:0]    w_pc_req_nxt;
   logic [XPR_LEN-1:0]    r_pc_if;
   logic [XPR_LEN-1:0]    w_pc_if_nxt;
   logic [XPR_LEN-1:0]    r_redir_pc;
   logic [XPR_LEN-1:0]    w_redir_pc_nxt;
   logic                  r_kill;
   logic                  w_kill_nxt;
   logic                  r_inst_valid;
   logic                  w_inst_valid_nxt;
   logic                  r_err;
   logic                  w_err_nxt;
   logic [INST_WIDTH-1:0] r_inst;
   logic [INST_WIDTH-1:0] w_inst_nxt;
   logic                  w_req;
   logic [XPR_LEN-1:0]    w_addr;
   logic                  w_hold_issue;

   // Leaving HOLD happens on acceptance or on any redirect (which ignores ready)
   assign w_hold_issue = inst_ready_i | redirect_i;

   // Request port: REQ replays the latched address, HOLD issues the mux output directly
   always_comb begin
      w_req  = 1'b0;
      w_addr = r_pc_req;
      case (r_state)
         FETCH_S_REQ: begin
            w_req  = 1'b1;
            w_addr = r_pc_req;
         end
         FETCH_S_HOLD: begin
            if (w_hold_issue) begin
               w_req  = 1'b1;
               w_addr = pc_pif_i;
            end else begin
               w_req  = 1'b0;
               w_addr = r_pc_req;
            end
         end
         default: begin
            w_req  = 1'b0;
            w_addr = r_pc_req;
         end
      endcase
   end

   // Next-state and datapath updates for the fetch FSM
   always_comb begin
      w_state_nxt      = r_state;
      w_pc_req_nxt     = r_pc_req;
      w_pc_if_nxt      = r_pc_if;
      w_redir_pc_nxt   = r_redir_pc;
      w_kill_nxt       = r_kill;
      w_inst_valid_nxt = r_inst_valid;
      w_err_nxt        = r_err;
      w_inst_nxt       = r_inst;
      case (r_state)
         FETCH_S_REQ: begin
            // A redirect cannot withdraw the request; remember the target and squash its reply
            if (redirect_i) begin
               w_kill_nxt     = 1'b1;
               w_redir_pc_nxt = pc_pif_i;
            end else begin
               w_kill_nxt     = r_kill;
            end
            if (imem_gnt_i) begin
               w_pc_if_nxt = r_pc_req;
               w_state_nxt = FETCH_S_WAIT;
            end else begin
               w_state_nxt = FETCH_S_REQ;
            end
         end
         FETCH_S_WAIT: begin
            if (imem_rvalid_i) begin
               if (redirect_i) begin
                  w_kill_nxt   = 1'b0;
                  w_pc_req_nxt = pc_pif_i;
                  w_pc_if_nxt  = pc_pif_i;
                  w_state_nxt  = FETCH_S_REQ;
               end else if (r_kill) begin
                  w_kill_nxt   = 1'b0;
                  w_pc_req_nxt = r_redir_pc;
                  w_pc_if_nxt  = r_redir_pc;
                  w_state_nxt  = FETCH_S_REQ;
               end else begin
                  w_inst_nxt       = imem_rdata_i;
                  w_err_nxt        = imem_err_i;
                  w_inst_valid_nxt = 1'b1;
                  w_state_nxt      = FETCH_S_HOLD;
               end
            end else if (redirect_i) begin
               w_kill_nxt     = 1'b1;
               w_redir_pc_nxt = pc_pif_i;
            end else begin
               w_state_nxt = FETCH_S_WAIT;
            end
         end
         FETCH_S_HOLD: begin
            if (w_hold_issue) begin
               w_inst_valid_nxt = 1'b0;
               if (imem_gnt_i) begin
                  w_pc_if_nxt = pc_pif_i;
                  w_state_nxt = FETCH_S_WAIT;
               end else begin
                  w_pc_req_nxt = pc_pif_i;
                  w_state_nxt  = FETCH_S_REQ;
               end
            end else begin
               w_state_nxt = FETCH_S_HOLD;
            end
         end
         default: begin
            w_state_nxt      = FETCH_S_REQ;
            w_kill_nxt       = 1'b0;
            w_inst_valid_nxt = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= FETCH_S_REQ;
         r_pc_req     <= RESET_PC;
         r_pc_if      <= RESET_PC;
         r_redir_pc   <= RESET_PC;
         r_kill       <= 1'b0;
         r_inst_valid <= 1'b0;
         r_err        <= 1'b0;
         r_inst       <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc_req     <= w_pc_req_nxt;
         r_pc_if      <= w_pc_if_nxt;
         r_redir_pc   <= w_redir_pc_nxt;
         r_kill       <= w_kill_nxt;
         r_inst_valid <= w_inst_valid_nxt;
         r_err        <= w_err_nxt;
         r_inst       <= w_inst_nxt;
      end
   end

   assign imem_req_o   = w_req;
   assign imem_addr_o  = w_addr;
   assign inst_o       = r_inst;
   assign inst_valid_o = r_inst_valid;
   assign pc_if_o      = r_pc_if;
   assign fetch_err_o  = r_err;
   assign compressed_o = is_compressed(r_inst[1:0]);

endmodule
